// File: rtl/led_pulse_stretch_if.sv
// led_pulse_stretch_if
//   Groups the event/status signals of led_pulse_stretch.
//   master : core-side driver (event_in, clr_ovf out; status in)
//   slave  : the stretcher itself (event_in, clr_ovf in; status out)
//   Signals:
//     event_in  event strobe, one event per high cycle
//     clr_ovf   synchronous clear of the overflow flag
//     led_out   LED drive, 1 = lit
//     busy      1 while a pulse or its off-gap is in progress
//     pending   queued events not yet shown
//     overflow  sticky: an event was dropped on a full queue
interface led_pulse_stretch_if #(
  parameter int PEND_W = 3
);
  logic              event_in;
  logic              clr_ovf;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output event_in, clr_ovf,
    input  led_out, busy, pending, overflow
  );

  modport slave (
    input  event_in, clr_ovf,
    output led_out, busy, pending, overflow
  );
endinterface

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch
//   Stretches single-cycle core events into visible LED pulses. Each event
//   lights the LED for HOLD = 2^(N-1) cycles; events arriving while a pulse
//   or off-gap is in progress are counted and replayed one by one, each
//   separated by a forced off-time GAP = 2^(GAP_N-1) cycles.
//   Ports:
//     clk      system clock
//     n_reset  asynchronous reset, active low
//     bus      led_pulse_stretch_if.slave (event_in, clr_ovf in;
//              led_out, busy, pending, overflow out, all registered)
//   Build option:
//     LED_STRETCH_RETRIGGER_EN - an event while lit restarts the on-time
//     instead of being queued; events during the off-gap still queue.
module led_pulse_stretch #(
  parameter int N      = 13,
  parameter int GAP_N  = 12,
  parameter int PEND_W = 3
) (
  input  logic               clk,
  input  logic               n_reset,
  led_pulse_stretch_if.slave bus
);

  localparam int CW = (N > GAP_N) ? N : GAP_N;

  localparam logic [CW-1:0]     HOLD_LAST = CW'((64'd1 << (N - 1)) - 64'd1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'((64'd1 << (GAP_N - 1)) - 64'd1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              ovf_q,   ovf_d;
  logic              led_q,   led_d;
  logic              busy_q,  busy_d;
  logic              enq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~bus.clr_ovf;
    enq     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.event_in) state_d = S_ON;
      end

      S_ON: begin
`ifdef LED_STRETCH_RETRIGGER_EN
        if (bus.event_in) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
`else
        enq = bus.event_in;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
`endif
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          // An event on the exit edge takes the slot being freed: with a
          // non-empty queue the count nets out unchanged, with an empty
          // queue the event is shown directly and never queued.
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = S_ON;
            if (!bus.event_in) pend_d = pend_q - PEND_W'(1);
          end else if (bus.event_in) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          enq = bus.event_in;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Drop-and-flag on a full queue; set beats a simultaneous clear.
    if (enq) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end

    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule
